vlsu_seg_iterator: RTL
======================

# vlsu_seg_iterator

Upstream stage of the VLSU transaction control unit. Accepts one strided vector memory request at a time and walks it in order: group (outer), segment (middle), 4 KiB page-bounded transaction (inner). Emits one meta beat per AXI transaction on a valid/ready channel that feeds the transaction control unit's meta input. All addresses and lengths are in nibbles; a page is 8192 nibbles (4 KiB).

## Interface
- `AddrWidth`, default `riva_pkg::ELEN`: nibble address width.
- `SegLenWidth`, default 20: width of the segment length field.
- `CntWidth`, default 16: width of the group and segment count fields.
- `TxnCntWidth`, derived as `SegLenWidth-12`: width of `txnCnt` and `txnNum`.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_i` in `vlsu_req_t` with fields:
  - `reqId`, `isLoad`
  - `baseAddr` (`AddrWidth`)
  - `segNibbles` (`SegLenWidth`, must be ≥ 1)
  - `segStride`, `grpStride` (`AddrWidth`)
  - `nSeg`, `nGrp` (`CntWidth`, value is count−1)
- `meta_valid_o` out 1: meta beat valid.
- `meta_ready_i` in 1: meta beat ready.
- `meta_glb_o` out `meta_glb_t` with fields `reqId`, `isLoad`, `rmnSeg`, `rmnGrp`.
- `meta_seglv_o` out `meta_seglv_t` with fields `segBaseAddr`, `txnCnt`, `txnNum`, `ltN` (14 bits).
- `busy_o` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM has three states: IDLE, PREP, EMIT.
- **IDLE**
  - `req_ready_o`=1.
  - On a request handshake:
    - latch `req_i`;
    - `grpBase`=`segBase`=`baseAddr`;
    - `rmnGrp`=`nGrp`, `rmnSeg`=`nSeg`;
    - go to PREP.
- **PREP** (one cycle per segment). Compute and register:
  - `pageOff`=`segBase[12:0]`;
  - `end`=`pageOff`+`segNibbles` (`SegLenWidth+1` bits);
  - `txnNum`=(`end`−1)>>13;
  - `ltN`=`end`−(`txnNum`<<13), range 1..8192;
  - `txnCnt`=0.
  - Go to EMIT.
- **EMIT**
  - `meta_valid_o`=1 with the registered fields.
  - On a meta handshake:
    - If `txnCnt`≠`txnNum`: `txnCnt`++ and stay in EMIT.
    - Else if `rmnSeg`≠0: `rmnSeg`−−, `segBase`+=`segStride`, go to PREP.
    - Else if `rmnGrp`≠0: `rmnGrp`−−, `rmnSeg`=`nSeg`, `grpBase`+=`grpStride`, `segBase`=new `grpBase`, go to PREP.
    - Else go to IDLE.
- `segBaseAddr` stays constant for every transaction of a segment. The downstream unit derives the transaction address from `segBaseAddr` and `txnCnt`.
- The final beat has `rmnGrp`=0, `rmnSeg`=0 and `txnCnt`=`txnNum`.
- Address arithmetic wraps modulo 2^`AddrWidth`; overflow is not flagged.
- `segNibbles`=0 is illegal; a simulation assertion fires when such a request is accepted.

## Timing
- Reset values:
  - `req_ready_o`=1 (IDLE);
  - `meta_valid_o`=0, `busy_o`=0;
  - `meta_glb_o`='0, `meta_seglv_o`='0;
  - all internal registers are 0.
- Latency: request handshake in cycle t gives the first `meta_valid_o` in cycle t+2.
- Throughput: a segment of n transactions occupies n+1 cycles with no backpressure (one PREP bubble per segment).
- Handshake rules:
  - Once `meta_valid_o` is high, it and all meta fields hold stable until `meta_ready_i` is sampled high.
  - `meta_valid_o` never drops without a handshake.
- After the final beat's handshake, the block is in IDLE the next cycle. A new request can be accepted in that cycle; there is no overlap between requests.
- `req_ready_o` is registered from state and does not depend on `meta_ready_i`.
- Reset asserted mid-request: the in-flight request is discarded and all outputs return to reset values asynchronously.

## Structure
- `vlsu_pkg` holds `vlsu_req_t`, `meta_glb_t`, `meta_seglv_t`, the page constants (13-bit page offset, 8192 nibbles) and the FSM state enum.
- The transaction control unit imports the same `meta_glb_t` and `meta_seglv_t` definitions.
- Single module with no sub-module. The length computation (`pageOff`, `txnNum`, `ltN`) sits in a local function.

## Test plan
- **Single transaction.** `baseAddr`=0x1000, `segNibbles`=0x100, `nSeg`=0, `nGrp`=0 → one beat: `segBaseAddr`=0x1000, `txnNum`=0, `txnCnt`=0, `ltN`=0x1100, `rmnSeg`=0, `rmnGrp`=0; first valid 2 cycles after the request; `req_ready_o` back to 1 the cycle after.
- **Page crossing.** `baseAddr`=0x1F00, `segNibbles`=0x200 → two beats with `txnNum`=1, `txnCnt`=0 then 1, `ltN`=0x100.
- **Exact page end.** `baseAddr`=0x1000, `segNibbles`=0x1000 → one beat with `txnNum`=0, `ltN`=8192.
- **Strides.** `segStride`=0x40, `grpStride`=0x1000, `nSeg`=2, `nGrp`=1, `segNibbles`=0x10, `baseAddr`=0 → six beats, `segBaseAddr` 0, 0x40, 0x80, 0x1000, 0x1040, 0x1080; `rmnSeg` 2, 1, 0, 2, 1, 0; `rmnGrp` 1, 1, 1, 0, 0, 0.
- **Backpressure.** Random `meta_ready_i` on the page-crossing case → fields stable while stalled, beat sequence identical, no lost or duplicated beats.
- **Reset mid-request.** Assert `rst_ni`=0 during EMIT → outputs at reset values immediately; after release a new request runs from scratch.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types for the VLSU request iterator and transaction control unit.
// Holds the request and meta beat structs, the page constants and FSM states.
package vlsu_pkg;

  localparam int unsigned ELEN         = 64;
  localparam int unsigned ADDR_W       = ELEN;
  localparam int unsigned SEG_LEN_W    = 20;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned TXN_CNT_W    = SEG_LEN_W - 12;
  localparam int unsigned REQ_ID_W     = 8;
  localparam int unsigned LTN_W        = 14;
  localparam int unsigned PAGE_OFF_W   = 13;
  localparam int unsigned PAGE_NIBBLES = 8192;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  typedef struct packed {
    logic [REQ_ID_W-1:0]  reqId;
    logic                 isLoad;
    logic [ADDR_W-1:0]    baseAddr;
    logic [SEG_LEN_W-1:0] segNibbles;
    logic [ADDR_W-1:0]    segStride;
    logic [ADDR_W-1:0]    grpStride;
    logic [CNT_W-1:0]     nSeg;
    logic [CNT_W-1:0]     nGrp;
  } vlsu_req_t;

  typedef struct packed {
    logic [REQ_ID_W-1:0] reqId;
    logic                isLoad;
    logic [CNT_W-1:0]    rmnSeg;
    logic [CNT_W-1:0]    rmnGrp;
  } meta_glb_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    segBaseAddr;
    logic [TXN_CNT_W-1:0] txnCnt;
    logic [TXN_CNT_W-1:0] txnNum;
    logic [LTN_W-1:0]     ltN;
  } meta_seglv_t;

  typedef struct packed {
    logic [TXN_CNT_W-1:0] txnNum;
    logic [LTN_W-1:0]     ltN;
  } seg_len_t;

endpackage

// File: rtl/vlsu_seg_iterator.sv
// Walks a strided vector request group/segment/page-transaction and emits one
// meta beat per AXI transaction. Ports: clk_i, rst_ni, req_valid_i/ready_o,
// req_i, meta_valid_o/ready_i, meta_glb_o, meta_seglv_o, busy_o.
module vlsu_seg_iterator
  import vlsu_pkg::*;
#(
  parameter int unsigned AddrWidth   = ADDR_W,
  parameter int unsigned SegLenWidth = SEG_LEN_W,
  parameter int unsigned CntWidth    = CNT_W,
  parameter int unsigned TxnCntWidth = SegLenWidth - 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  vlsu_req_t   req_i,
  output logic        meta_valid_o,
  input  logic        meta_ready_i,
  output meta_glb_t   meta_glb_o,
  output meta_seglv_t meta_seglv_o,
  output logic        busy_o
);

  localparam logic [SegLenWidth:0] One = 1;

  // Page-bounded split of one segment: how many extra transactions follow
  // the first one and how many nibbles the last transaction carries.
  function automatic seg_len_t calc_len(
    input logic [PAGE_OFF_W-1:0]  page_off,
    input logic [SegLenWidth-1:0] nib
  );
    logic [SegLenWidth:0]   seg_end;
    logic [SegLenWidth:0]   last_page;
    logic [TxnCntWidth-1:0] num;
    seg_len_t               r;
    seg_end   = {{(SegLenWidth+1-PAGE_OFF_W){1'b0}}, page_off}
              + {1'b0, nib};
    num       = TxnCntWidth'((seg_end - One) >> PAGE_OFF_W);
    last_page = {num, {PAGE_OFF_W{1'b0}}};
    r.txnNum  = num;
    r.ltN     = LTN_W'(seg_end - last_page);
    return r;
  endfunction

  logic [1:0]             state;
  logic [REQ_ID_W-1:0]    req_id;
  logic                   is_load;
  logic [SegLenWidth-1:0] seg_nib;
  logic [AddrWidth-1:0]   seg_stride;
  logic [AddrWidth-1:0]   grp_stride;
  logic [CntWidth-1:0]    n_seg;
  logic [AddrWidth-1:0]   grp_base;
  logic [AddrWidth-1:0]   seg_base;
  logic [CntWidth-1:0]    rmn_seg;
  logic [CntWidth-1:0]    rmn_grp;
  logic [TxnCntWidth-1:0] txn_cnt;
  logic [TxnCntWidth-1:0] txn_num;
  logic [LTN_W-1:0]       lt_n;

  logic                   st_idle;
  logic                   st_prep;
  logic                   st_emit;
  logic [AddrWidth-1:0]   grp_next;
  seg_len_t               len;

  assign st_idle  = (state == ST_IDLE);
  assign st_prep  = (state == ST_PREP);
  assign st_emit  = (state == ST_EMIT);
  assign grp_next = grp_base + grp_stride;
  assign len      = calc_len(seg_base[PAGE_OFF_W-1:0], seg_nib);

  assign req_ready_o  = st_idle;
  assign meta_valid_o = st_emit;
  assign busy_o       = !st_idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      req_id     <= '0;
      is_load    <= 1'b0;
      seg_nib    <= '0;
      seg_stride <= '0;
      grp_stride <= '0;
      n_seg      <= '0;
      grp_base   <= '0;
      seg_base   <= '0;
      rmn_seg    <= '0;
      rmn_grp    <= '0;
      txn_cnt    <= '0;
      txn_num    <= '0;
      lt_n       <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (req_valid_i) begin
            req_id     <= req_i.reqId;
            is_load    <= req_i.isLoad;
            seg_nib    <= req_i.segNibbles;
            seg_stride <= req_i.segStride;
            grp_stride <= req_i.grpStride;
            n_seg      <= req_i.nSeg;
            grp_base   <= req_i.baseAddr;
            seg_base   <= req_i.baseAddr;
            rmn_seg    <= req_i.nSeg;
            rmn_grp    <= req_i.nGrp;
            state      <= ST_PREP;
          end
        end
        st_prep: begin
          txn_num <= len.txnNum;
          lt_n    <= len.ltN;
          txn_cnt <= '0;
          state   <= ST_EMIT;
        end
        st_emit: begin
          if (meta_ready_i) begin
            if (txn_cnt != txn_num) begin
              txn_cnt <= txn_cnt + 1'b1;
            end else if (rmn_seg != '0) begin
              rmn_seg  <= rmn_seg - 1'b1;
              seg_base <= seg_base + seg_stride;
              state    <= ST_PREP;
            end else if (rmn_grp != '0) begin
              rmn_grp  <= rmn_grp - 1'b1;
              rmn_seg  <= n_seg;
              grp_base <= grp_next;
              seg_base <= grp_next;
              state    <= ST_PREP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    meta_glb_o        = '0;
    meta_glb_o.reqId  = req_id;
    meta_glb_o.isLoad = is_load;
    meta_glb_o.rmnSeg = rmn_seg;
    meta_glb_o.rmnGrp = rmn_grp;
  end

  always_comb begin
    meta_seglv_o             = '0;
    meta_seglv_o.segBaseAddr = seg_base;
    meta_seglv_o.txnCnt      = txn_cnt;
    meta_seglv_o.txnNum      = txn_num;
    meta_seglv_o.ltN         = lt_n;
  end

  // A zero-length segment has no meaningful transaction split.
  a_seg_nonzero: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && req_ready_o) |-> (req_i.segNibbles != '0)
  );

endmodule
